ysyx_axi4_mem_slave: RTL and testbench

//  AXI4 slave (responder) backed by an internal word-addressed memory; the responder end of the

---
 rtl/ysyx_axi4_mem_slave.sv | 226 ++++++++++++++++++++++
 tb/tb_ysyx_axi4_mem_slave.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_axi4_mem_slave.sv
// AXI4 memory responder backed by an internal 64-bit word array.
// Independent read and write FSMs, one outstanding transaction each, full per-beat error decode.
module ysyx_axi4_mem_slave #(
  parameter int unsigned         ADDR_W    = 32,
  parameter int unsigned         DATA_W    = 64,
  parameter int unsigned         ID_W      = 4,
  parameter logic [ADDR_W-1:0]   MEM_BASE  = 32'h0f00_0000,
  parameter int unsigned         MEM_WORDS = 1024
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [ID_W-1:0]     arid,
  input  logic [ADDR_W-1:0]   araddr,
  input  logic [7:0]          arlen,
  input  logic [2:0]          arsize,
  input  logic [1:0]          arburst,
  input  logic                arvalid,
  output logic                arready,
  output logic [ID_W-1:0]     rid,
  output logic [DATA_W-1:0]   rdata,
  output logic [1:0]          rresp,
  output logic                rlast,
  output logic                rvalid,
  input  logic                rready,
  input  logic [ID_W-1:0]     awid,
  input  logic [ADDR_W-1:0]   awaddr,
  input  logic [7:0]          awlen,
  input  logic [2:0]          awsize,
  input  logic [1:0]          awburst,
  input  logic                awvalid,
  output logic                awready,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] wstrb,
  input  logic                wlast,
  input  logic                wvalid,
  output logic                wready,
  output logic [ID_W-1:0]     bid,
  output logic [1:0]          bresp,
  output logic                bvalid,
  input  logic                bready
);

  localparam int unsigned IDX_W = $clog2(MEM_WORDS);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [0:0] R_IDLE = 1'b0;
  localparam logic [0:0] R_DATA = 1'b1;

  localparam logic [1:0] W_IDLE = 2'd0;
  localparam logic [1:0] W_DATA = 2'd1;
  localparam logic [1:0] W_RESP = 2'd2;

  logic [DATA_W-1:0] mem [MEM_WORDS];

  function automatic logic [1:0] beat_resp(input logic [ADDR_W-1:0] a,
                                           input logic [2:0] sz,
                                           input logic [1:0] bt);
    logic [ADDR_W-1:0] off;
    off = a - MEM_BASE;
    if (a < MEM_BASE || (off >> 3) >= ADDR_W'(MEM_WORDS)) return RESP_DECERR;
    if (sz > 3'd3 || bt[1]) return RESP_SLVERR;
    return RESP_OKAY;
  endfunction

  function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_W-1:0] a);
    logic [ADDR_W-1:0] off;
    off = a - MEM_BASE;
    return IDX_W'(off >> 3);
  endfunction

  // FIXED holds the address; INCR (and the error bursts) step by the beat size.
  function automatic logic [ADDR_W-1:0] step_addr(input logic [ADDR_W-1:0] a,
                                                  input logic [2:0] sz,
                                                  input logic [1:0] bt);
    return (bt == 2'b00) ? a : a + (ADDR_W'(1) << sz);
  endfunction

  // ---------------- read channel ----------------
  logic [0:0]        r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [7:0]        r_len;
  logic [7:0]        r_beat;
  logic [2:0]        r_size;
  logic [1:0]        r_burst;
  logic [ADDR_W-1:0] r_next_addr;
  logic [ADDR_W-1:0] r_load_addr;
  logic [1:0]        r_load_resp;
  logic [DATA_W-1:0] r_load_data;

  // The beat loaded next is beat 0 of a new burst in IDLE, otherwise the stepped address.
  always_comb begin
    r_next_addr = step_addr(r_addr, r_size, r_burst);
    r_load_addr = r_next_addr;
    r_load_resp = beat_resp(r_next_addr, r_size, r_burst);
    if (r_state == R_IDLE) begin
      r_load_addr = araddr;
      r_load_resp = beat_resp(araddr, arsize, arburst);
    end
    r_load_data = (r_load_resp == RESP_OKAY) ? mem[word_idx(r_load_addr)] : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= R_IDLE;
      rid     <= '0;
      rdata   <= '0;
      rresp   <= RESP_OKAY;
      r_addr  <= '0;
      r_len   <= '0;
      r_beat  <= '0;
      r_size  <= '0;
      r_burst <= '0;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (arvalid) begin
            rid     <= arid;
            r_addr  <= araddr;
            r_len   <= arlen;
            r_size  <= arsize;
            r_burst <= arburst;
            r_beat  <= '0;
            rdata   <= r_load_data;
            rresp   <= r_load_resp;
            r_state <= R_DATA;
          end
        end
        default: begin
          if (rready) begin
            if (r_beat == r_len) begin
              r_state <= R_IDLE;
            end else begin
              r_addr <= r_next_addr;
              r_beat <= r_beat + 8'd1;
              rdata  <= r_load_data;
              rresp  <= r_load_resp;
            end
          end
        end
      endcase
    end
  end

  assign arready = (r_state == R_IDLE);
  assign rvalid  = (r_state == R_DATA);
  assign rlast   = rvalid && (r_beat == r_len);

  // ---------------- write channel ----------------
  logic [1:0]        w_state;
  logic [ADDR_W-1:0] w_addr;
  logic [7:0]        w_len;
  logic [8:0]        w_cnt;
  logic [2:0]        w_size;
  logic [1:0]        w_burst;
  logic [1:0]        w_addr_resp;
  logic [1:0]        w_beat_err;
  logic              w_proto_err;
  logic              w_we;
  logic [IDX_W-1:0]  w_idx;

  // A misplaced wlast (early, late, or missing) raises the response to at least SLVERR.
  always_comb begin
    w_addr_resp = beat_resp(w_addr, w_size, w_burst);
    w_proto_err = (wlast && (w_cnt != {1'b0, w_len})) || (!wlast && (w_cnt > {1'b0, w_len}));
    w_beat_err  = w_addr_resp;
    if (w_proto_err && (w_beat_err < RESP_SLVERR)) w_beat_err = RESP_SLVERR;
    w_we  = (w_state == W_DATA) && wvalid && (w_addr_resp == RESP_OKAY);
    w_idx = word_idx(w_addr);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_state <= W_IDLE;
      bid     <= '0;
      bresp   <= RESP_OKAY;
      w_addr  <= '0;
      w_len   <= '0;
      w_cnt   <= '0;
      w_size  <= '0;
      w_burst <= '0;
    end else begin
      case (w_state)
        W_IDLE: begin
          if (awvalid) begin
            bid     <= awid;
            w_addr  <= awaddr;
            w_len   <= awlen;
            w_size  <= awsize;
            w_burst <= awburst;
            w_cnt   <= '0;
            bresp   <= RESP_OKAY;
            w_state <= W_DATA;
          end
        end
        W_DATA: begin
          if (wvalid) begin
            if (w_beat_err > bresp) bresp <= w_beat_err;
            w_addr <= step_addr(w_addr, w_size, w_burst);
            if (w_cnt != 9'd256) w_cnt <= w_cnt + 9'd1;
            if (wlast) w_state <= W_RESP;
          end
        end
        W_RESP: begin
          if (bready) w_state <= W_IDLE;
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  assign awready = (w_state == W_IDLE);
  assign wready  = (w_state == W_DATA);
  assign bvalid  = (w_state == W_RESP);

  always_ff @(posedge clk) begin
    if (w_we) begin
      for (int unsigned i = 0; i < DATA_W / 8; i++) begin
        if (wstrb[i]) mem[w_idx][i*8 +: 8] <= wdata[i*8 +: 8];
      end
    end
  end

endmodule

// File: tb/tb_ysyx_axi4_mem_slave.sv
// Directed self-checking bench for the AXI4 memory responder.
module tb_ysyx_axi4_mem_slave;

  localparam logic [31:0] BASE = 32'h0f00_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  arid = '0, rid, awid = '0, bid;
  logic [31:0] araddr = '0, awaddr = '0;
  logic [7:0]  arlen = '0, awlen = '0, wstrb = '0;
  logic [2:0]  arsize = '0, awsize = '0;
  logic [1:0]  arburst = '0, awburst = '0, rresp, bresp;
  logic        arvalid = 1'b0, arready, rlast, rvalid, rready = 1'b0;
  logic        awvalid = 1'b0, awready, wlast = 1'b0, wvalid = 1'b0, wready;
  logic        bvalid, bready = 1'b0;
  logic [63:0] rdata, wdata = '0;

  ysyx_axi4_mem_slave #(.ADDR_W(32), .DATA_W(64), .ID_W(4), .MEM_BASE(BASE), .MEM_WORDS(1024)) dut (
    .clk(clk), .rst(rst),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  logic [63:0] wbuf [8];
  logic [7:0]  sbuf [8];
  logic [63:0] rd_data [16];
  logic [1:0]  rd_resp [16];
  logic        rd_last [16];
  logic [3:0]  rd_id   [16];
  int          rd_n, rd_lat, stab_viol;
  logic        rv_after;
  logic [1:0]  b_resp;
  logic [3:0]  b_id;

  task automatic timeout(input string what);
    tests++; fails++;
    $display("FAIL timeout_%s: got no handshake, required one within 50 cycles", what);
  endtask

  task automatic axi_write(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                           input logic [1:0] burst, input logic [3:0] id, input int nbeats);
    int k;
    @(negedge clk);
    awid = id; awaddr = addr; awlen = len; awsize = size; awburst = burst; awvalid = 1'b1;
    k = 0;
    while (!awready && k < 50) begin @(negedge clk); k++; end
    if (k >= 50) timeout("aw");
    @(negedge clk);
    awvalid = 1'b0;
    for (int i = 0; i < nbeats; i++) begin
      wdata = wbuf[i]; wstrb = sbuf[i]; wlast = (i == nbeats - 1); wvalid = 1'b1;
      k = 0;
      while (!wready && k < 50) begin @(negedge clk); k++; end
      if (k >= 50) timeout("w");
      @(negedge clk);
    end
    wvalid = 1'b0; wlast = 1'b0;
    bready = 1'b1;
    k = 0;
    while (!bvalid && k < 50) begin @(negedge clk); k++; end
    if (k >= 50) timeout("b");
    b_resp = bresp; b_id = bid;
    @(negedge clk);
    bready = 1'b0;
  endtask

  task automatic axi_read(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                          input logic [1:0] burst, input logic [3:0] id, input logic toggle);
    int k;
    logic stalled;
    logic [63:0] pd;
    logic [1:0] pr;
    logic pl;
    @(negedge clk);
    arid = id; araddr = addr; arlen = len; arsize = size; arburst = burst; arvalid = 1'b1;
    k = 0;
    while (!arready && k < 50) begin @(negedge clk); k++; end
    if (k >= 50) timeout("ar");
    @(negedge clk);
    arvalid = 1'b0;
    rd_lat = 0;
    while (!rvalid && rd_lat < 50) begin @(negedge clk); rd_lat++; end
    rd_n = 0; stab_viol = 0; stalled = 1'b0; pd = '0; pr = '0; pl = 1'b0; rv_after = 1'b1;
    k = 0;
    while (k < 200) begin
      rready = toggle ? logic'(k[0]) : 1'b1;
      if (rvalid) begin
        if (stalled && (rdata !== pd || rresp !== pr || rlast !== pl)) stab_viol++;
        if (rready) begin
          if (rd_n < 16) begin
            rd_data[rd_n] = rdata; rd_resp[rd_n] = rresp; rd_last[rd_n] = rlast; rd_id[rd_n] = rid;
          end
          rd_n++;
          stalled = 1'b0;
          if (rlast) begin
            @(negedge clk);
            rv_after = rvalid;
            break;
          end
        end else begin
          stalled = 1'b1; pd = rdata; pr = rresp; pl = rlast;
        end
      end
      @(negedge clk);
      k++;
    end
    rready = 1'b0;
    if (k >= 200) timeout("r");
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    tests++;
    if ({arready, awready, rvalid, rlast, wready, bvalid} !== 6'b110000) begin
      fails++;
      $display("FAIL reset_handshake: got %b required 110000", {arready, awready, rvalid, rlast, wready, bvalid});
    end
    tests++;
    if ({rid, rdata, rresp, bid, bresp} !== '0) begin
      fails++;
      $display("FAIL reset_regs: got rid=%h rdata=%h rresp=%b bid=%h bresp=%b required all zero",
               rid, rdata, rresp, bid, bresp);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single_read();
    wbuf[0] = 64'h0123_4567_89ab_cdef; sbuf[0] = 8'hff;
    axi_write(BASE + 32'h10, 8'd0, 3'd3, 2'b01, 4'h2, 1);
    tests++;
    if (b_resp !== 2'b00 || b_id !== 4'h2) begin
      fails++; $display("FAIL single_bresp: got resp=%b id=%h required 00/2", b_resp, b_id);
    end
    axi_read(BASE + 32'h10, 8'd0, 3'd3, 2'b01, 4'h5, 1'b0);
    tests++;
    if (rd_lat !== 0) begin
      fails++; $display("FAIL single_latency: got %0d required 0 extra cycles", rd_lat);
    end
    tests++;
    if (rd_n !== 1 || rd_data[0] !== 64'h0123_4567_89ab_cdef || rd_resp[0] !== 2'b00 ||
        rd_last[0] !== 1'b1 || rd_id[0] !== 4'h5) begin
      fails++;
      $display("FAIL single_beat: got n=%0d data=%h resp=%b last=%b id=%h required 1/0123456789abcdef/00/1/5",
               rd_n, rd_data[0], rd_resp[0], rd_last[0], rd_id[0]);
    end
    tests++;
    if (rv_after !== 1'b0) begin
      fails++; $display("FAIL single_rvalid_drop: got %b required 0", rv_after);
    end
  endtask

  task automatic test_burst();
    logic [63:0] exp [4];
    exp[0] = 64'h1111_1111_1111_1111; exp[1] = 64'h2222_2222_2222_2222;
    exp[2] = 64'h3333_3333_3333_3333; exp[3] = 64'h4444_4444_4444_4444;
    for (int i = 0; i < 4; i++) begin wbuf[i] = exp[i]; sbuf[i] = 8'hff; end
    axi_write(BASE, 8'd3, 3'd3, 2'b01, 4'h3, 4);
    tests++;
    if (b_resp !== 2'b00 || b_id !== 4'h3) begin
      fails++; $display("FAIL burst_bresp: got resp=%b id=%h required 00/3", b_resp, b_id);
    end
    axi_read(BASE, 8'd3, 3'd3, 2'b01, 4'h7, 1'b1);
    tests++;
    if (rd_n !== 4) begin
      fails++; $display("FAIL burst_count: got %0d required 4", rd_n);
    end
    for (int i = 0; i < 4; i++) begin
      tests++;
      if (rd_data[i] !== exp[i] || rd_last[i] !== (i == 3) || rd_resp[i] !== 2'b00 || rd_id[i] !== 4'h7) begin
        fails++;
        $display("FAIL burst_beat%0d: got data=%h last=%b resp=%b id=%h required %h/%b/00/7",
                 i, rd_data[i], rd_last[i], rd_resp[i], rd_id[i], exp[i], (i == 3));
      end
    end
    tests++;
    if (stab_viol !== 0) begin
      fails++; $display("FAIL burst_stall_stable: got %0d changes while stalled required 0", stab_viol);
    end
  endtask

  task automatic test_strobe();
    wbuf[0] = 64'hffff_ffff_ffff_ffff; sbuf[0] = 8'hff;
    axi_write(BASE, 8'd0, 3'd3, 2'b01, 4'h1, 1);
    wbuf[0] = 64'haaaa_aaaa_bbbb_bbbb; sbuf[0] = 8'h0f;
    axi_write(BASE, 8'd0, 3'd3, 2'b01, 4'h1, 1);
    axi_read(BASE, 8'd0, 3'd3, 2'b01, 4'h1, 1'b0);
    tests++;
    if (rd_data[0] !== 64'hffff_ffff_bbbb_bbbb) begin
      fails++; $display("FAIL strobe_merge: got %h required ffffffffbbbbbbbb", rd_data[0]);
    end
  endtask

  task automatic test_errors();
    axi_read(32'h0000_0000, 8'd1, 3'd3, 2'b01, 4'h4, 1'b0);
    tests++;
    if (rd_n !== 2 || rd_resp[0] !== 2'b11 || rd_resp[1] !== 2'b11 || rd_data[0] !== '0 ||
        rd_data[1] !== '0 || rd_last[1] !== 1'b1) begin
      fails++;
      $display("FAIL decerr_low: got n=%0d resp=%b,%b data=%h,%h required 2 beats 11 zero",
               rd_n, rd_resp[0], rd_resp[1], rd_data[0], rd_data[1]);
    end
    axi_read(BASE + 32'h1ff8, 8'd0, 3'd3, 2'b01, 4'h4, 1'b0);
    tests++;
    if (rd_resp[0] !== 2'b00) begin
      fails++; $display("FAIL last_word_okay: got %b required 00", rd_resp[0]);
    end
    axi_read(BASE + 32'h2000, 8'd0, 3'd3, 2'b01, 4'h4, 1'b0);
    tests++;
    if (rd_resp[0] !== 2'b11 || rd_data[0] !== '0) begin
      fails++; $display("FAIL decerr_high: got resp=%b data=%h required 11/0", rd_resp[0], rd_data[0]);
    end
    axi_read(BASE, 8'd0, 3'd4, 2'b01, 4'h4, 1'b0);
    tests++;
    if (rd_resp[0] !== 2'b10 || rd_data[0] !== '0) begin
      fails++; $display("FAIL slverr_size: got resp=%b data=%h required 10/0", rd_resp[0], rd_data[0]);
    end
    wbuf[0] = 64'hdead_beef_dead_beef; sbuf[0] = 8'hff;
    axi_write(BASE + 32'h8, 8'd0, 3'd3, 2'b10, 4'h6, 1);
    tests++;
    if (b_resp !== 2'b10 || b_id !== 4'h6) begin
      fails++; $display("FAIL wrap_bresp: got resp=%b id=%h required 10/6", b_resp, b_id);
    end
    axi_read(BASE + 32'h8, 8'd0, 3'd3, 2'b01, 4'h4, 1'b0);
    tests++;
    if (rd_data[0] !== 64'h2222_2222_2222_2222) begin
      fails++; $display("FAIL wrap_no_write: got %h required 2222222222222222", rd_data[0]);
    end
  endtask

  task automatic test_wlast();
    wbuf[0] = 64'h5555_5555_5555_5555; wbuf[1] = 64'h6666_6666_6666_6666;
    sbuf[0] = 8'hff; sbuf[1] = 8'hff;
    axi_write(BASE + 32'h20, 8'd2, 3'd3, 2'b01, 4'h8, 2);
    tests++;
    if (b_resp !== 2'b10) begin
      fails++; $display("FAIL early_wlast: got %b required 10", b_resp);
    end
    wbuf[0] = 64'h0a0a_0a0a_0a0a_0a0a; wbuf[1] = 64'h0b0b_0b0b_0b0b_0b0b; wbuf[2] = 64'h0c0c_0c0c_0c0c_0c0c;
    for (int i = 0; i < 3; i++) sbuf[i] = 8'hff;
    axi_write(BASE + 32'h28, 8'd2, 3'd3, 2'b00, 4'h9, 3);
    tests++;
    if (b_resp !== 2'b00) begin
      fails++; $display("FAIL fixed_bresp: got %b required 00", b_resp);
    end
    axi_read(BASE + 32'h28, 8'd0, 3'd3, 2'b01, 4'h9, 1'b0);
    tests++;
    if (rd_data[0] !== 64'h0c0c_0c0c_0c0c_0c0c) begin
      fails++; $display("FAIL fixed_final: got %h required 0c0c0c0c0c0c0c0c", rd_data[0]);
    end
  endtask

  task automatic test_back_to_back();
    axi_read(BASE + 32'h18, 8'd1, 3'd3, 2'b00, 4'ha, 1'b0);
    tests++;
    if (rd_n !== 2 || rd_data[0] !== 64'h4444_4444_4444_4444 || rd_data[1] !== 64'h4444_4444_4444_4444) begin
      fails++; $display("FAIL fixed_read: got n=%0d %h,%h required 2 x 4444444444444444", rd_n, rd_data[0], rd_data[1]);
    end
    axi_read(BASE + 32'h8, 8'd1, 3'd2, 2'b01, 4'hb, 1'b0);
    tests++;
    if (rd_n !== 2 || rd_data[0] !== 64'h2222_2222_2222_2222 || rd_data[1] !== 64'h2222_2222_2222_2222 ||
        rd_id[1] !== 4'hb) begin
      fails++; $display("FAIL size2_step: got n=%0d %h,%h id=%h required 2 x 2222222222222222 id b",
                        rd_n, rd_data[0], rd_data[1], rd_id[1]);
    end
  endtask

  task automatic test_reset_mid();
    int k;
    @(negedge clk);
    arid = 4'hc; araddr = BASE; arlen = 8'd3; arsize = 3'd3; arburst = 2'b01; arvalid = 1'b1;
    k = 0;
    while (!arready && k < 50) begin @(negedge clk); k++; end
    if (k >= 50) timeout("ar_mid");
    @(negedge clk);
    arvalid = 1'b0; rready = 1'b1;
    repeat (2) @(negedge clk);
    tests++;
    if (rvalid !== 1'b1 || rdata !== 64'h3333_3333_3333_3333) begin
      fails++; $display("FAIL mid_beat2: got rvalid=%b data=%h required 1/3333333333333333", rvalid, rdata);
    end
    #2 rst = 1'b1;
    #1;
    tests++;
    if (rvalid !== 1'b0 || rlast !== 1'b0 || rdata !== '0) begin
      fails++; $display("FAIL mid_async_reset: got rvalid=%b rlast=%b rdata=%h required 0/0/0", rvalid, rlast, rdata);
    end
    rready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    tests++;
    if (arready !== 1'b1 || rvalid !== 1'b0) begin
      fails++; $display("FAIL mid_idle_after: got arready=%b rvalid=%b required 1/0", arready, rvalid);
    end
    axi_read(BASE + 32'h18, 8'd0, 3'd3, 2'b01, 4'hd, 1'b0);
    tests++;
    if (rd_n !== 1 || rd_data[0] !== 64'h4444_4444_4444_4444 || rd_id[0] !== 4'hd) begin
      fails++; $display("FAIL mid_new_ar: got n=%0d data=%h id=%h required 1/4444444444444444/d", rd_n, rd_data[0], rd_id[0]);
    end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_burst();
    test_strobe();
    test_errors();
    test_wlast();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion required finish before 500000");
    $fatal(1);
  end

endmodule
